// File: rtl/branch_resolver_pkg.sv
// Shared widths and constants for the branch resolution unit.
package branch_resolver_pkg;

   localparam int unsigned InstAddrBus = 32;
   localparam int unsigned ADDR_W_DEF  = InstAddrBus;
   localparam int unsigned DEPTH_DEF   = 4;

   // Sticky error vector layout
   localparam int unsigned ERR_W   = 2;
   localparam int unsigned ERR_OVF = 0;  // overflow / underflow
   localparam int unsigned ERR_ORD = 1;  // resolved PC differs from queue head

endpackage

// File: rtl/br_fifo.sv
// In-order FIFO of in-flight predictions with synchronous clear and occupancy count.
module br_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     clr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next pointer/count; clear wins over push and pop
   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (clr_i) begin
         wptr_d = '0;
         rptr_d = '0;
         cnt_d  = '0;
      end else begin
         if (push_i) wptr_d = wptr_q + PTR_W'(1);
         if (pop_i)  rptr_d = rptr_q + PTR_W'(1);
         cnt_d = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
      end
   end

   // Pointer and count state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   // Entry storage; contents are don't-care after reset
   always_ff @(posedge clk) begin
      if (push_i && !clr_i) mem_q[wptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rptr_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/branch_resolver.sv
// Compares resolved branches with recorded predictions, trains the predictor and flushes on mispredict.
module branch_resolver
   import branch_resolver_pkg::*;
#(
   parameter int unsigned DEPTH  = DEPTH_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              if_br_valid,
   input  logic [ADDR_W-1:0] if_pc,
   input  logic              if_jmp_e,
   input  logic [ADDR_W-1:0] if_pred,
   output logic              if_full,
   input  logic              ex_br_valid,
   input  logic [ADDR_W-1:0] ex_pc,
   input  logic              ex_taken,
   input  logic [ADDR_W-1:0] ex_target,
   output logic [ADDR_W-1:0] addr_r,
   output logic              jmp_r,
   output logic              change_e,
   output logic [ADDR_W-1:0] target_addr,
   output logic              flush,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic [ERR_W-1:0]  err
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned ENT_W = 2 * ADDR_W + 1;

   logic [ENT_W-1:0]  head_c;
   logic [ADDR_W-1:0] head_pc_c, head_pred_c;
   logic              head_jmp_c;
   logic [CNT_W-1:0]  count_c;
   logic full_c, empty_c, deq_req_c, deq_ok_c, pc_mis_c, mis_c;
   logic good_deq_c, enq_req_c, push_c, ovf_c;

   logic [ADDR_W-1:0] addr_r_q, addr_r_d, target_q, target_d, redirect_q, redirect_d;
   logic              jmp_r_q, jmp_r_d, change_e_q, change_e_d, flush_q, flush_d;
   logic [ERR_W-1:0]  err_q, err_d;

   br_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_c),
      .pop_i   (good_deq_c),
      .clr_i   (mis_c),
      .wdata_i ({if_pc, if_jmp_e, if_pred}),
      .rdata_o (head_c),
      .count_o (count_c)
   );

   assign {head_pc_c, head_jmp_c, head_pred_c} = head_c;

   assign full_c     = (count_c == CNT_W'(DEPTH));
   assign empty_c    = (count_c == '0);
   assign deq_req_c  = rdy && ex_br_valid;
   assign deq_ok_c   = deq_req_c && !empty_c;
   assign pc_mis_c   = (head_pc_c != ex_pc);
   assign mis_c      = deq_ok_c && (pc_mis_c || (ex_taken != head_jmp_c) ||
                                    (ex_taken && head_jmp_c && (ex_target != head_pred_c)));
   assign good_deq_c = deq_ok_c && !mis_c;
   // A full queue still accepts when the head retires correctly in the same cycle
   assign enq_req_c  = rdy && if_br_valid && !flush_q && !mis_c;
   assign push_c     = enq_req_c && (!full_c || good_deq_c);
   assign ovf_c      = (enq_req_c && full_c && !good_deq_c) || (deq_req_c && empty_c);

   // Next training/flush pulses; pulses hold across rdy=0 and drop at the next rdy=1 edge
   always_comb begin
      addr_r_d   = addr_r_q;
      jmp_r_d    = jmp_r_q;
      change_e_d = change_e_q;
      target_d   = target_q;
      flush_d    = flush_q;
      redirect_d = redirect_q;
      err_d      = err_q;
      if (rdy) begin
         jmp_r_d = deq_ok_c;
         flush_d = mis_c;
         if (deq_ok_c) begin
            addr_r_d   = ex_pc;
            change_e_d = ex_taken;
            target_d   = ex_target;
         end
         if (mis_c) redirect_d = ex_taken ? ex_target : ex_pc + ADDR_W'(4);
         err_d[ERR_OVF] = err_q[ERR_OVF] | ovf_c;
         err_d[ERR_ORD] = err_q[ERR_ORD] | (deq_ok_c && pc_mis_c);
      end
   end

   // Registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_r_q   <= '0;
         jmp_r_q    <= 1'b0;
         change_e_q <= 1'b0;
         target_q   <= '0;
         flush_q    <= 1'b0;
         redirect_q <= '0;
         err_q      <= '0;
      end else begin
         addr_r_q   <= addr_r_d;
         jmp_r_q    <= jmp_r_d;
         change_e_q <= change_e_d;
         target_q   <= target_d;
         flush_q    <= flush_d;
         redirect_q <= redirect_d;
         err_q      <= err_d;
      end
   end

   assign if_full     = full_c;
   assign addr_r      = addr_r_q;
   assign jmp_r       = jmp_r_q;
   assign change_e    = change_e_q;
   assign target_addr = target_q;
   assign flush       = flush_q;
   assign redirect_pc = redirect_q;
   assign err         = err_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: directed scenarios plus randomized traffic.
module tb_branch_resolver;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rdy = 1'b0;
   logic        if_br_valid = 1'b0;
   logic [31:0] if_pc = '0;
   logic        if_jmp_e = 1'b0;
   logic [31:0] if_pred = '0;
   logic        if_full;
   logic        ex_br_valid = 1'b0;
   logic [31:0] ex_pc = '0;
   logic        ex_taken = 1'b0;
   logic [31:0] ex_target = '0;
   logic [31:0] addr_r;
   logic        jmp_r;
   logic        change_e;
   logic [31:0] target_addr;
   logic        flush;
   logic [31:0] redirect_pc;
   logic [1:0]  err;

   always #5 clk = ~clk;

   branch_resolver #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .if_br_valid(if_br_valid), .if_pc(if_pc), .if_jmp_e(if_jmp_e), .if_pred(if_pred),
      .if_full(if_full),
      .ex_br_valid(ex_br_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
      .addr_r(addr_r), .jmp_r(jmp_r), .change_e(change_e), .target_addr(target_addr),
      .flush(flush), .redirect_pc(redirect_pc), .err(err)
   );

   typedef struct {logic [31:0] pc; logic je; logic [31:0] pred;} ent_t;
   typedef struct {logic [31:0] addr; logic chg; logic [31:0] tgt; logic fl; logic [31:0] rpc;} exp_t;

   ent_t       m_q[$];      // predictions the unit should be holding, oldest first
   exp_t       exp_q[$];    // pulses the unit owes the predictor/pipeline
   logic [1:0] m_err   = '0;
   logic       m_flush = 1'b0;
   int         tests = 0;
   int         fails = 0;
   exp_t       mon_e;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
      end
   endtask

   // Reference behaviour at one rising edge, from the current input values
   task automatic model_edge();
      ent_t h;
      logic mis;
      logic pcm;
      if (!rst || !rdy) return;
      mis = 1'b0;
      if (ex_br_valid) begin
         if (m_q.size() == 0) begin
            m_err[0] = 1'b1;
         end else begin
            h   = m_q[0];
            pcm = (h.pc != ex_pc);
            mis = pcm || (ex_taken != h.je) || (ex_taken && h.je && ex_target != h.pred);
            if (pcm) m_err[1] = 1'b1;
            exp_q.push_back('{ex_pc, ex_taken, ex_target, mis,
                              ex_taken ? ex_target : ex_pc + 32'd4});
            if (!mis) void'(m_q.pop_front());
         end
      end
      if (if_br_valid && !m_flush && !mis) begin
         if (m_q.size() < DEPTH) m_q.push_back('{if_pc, if_jmp_e, if_pred});
         else m_err[0] = 1'b1;
      end
      if (mis) m_q.delete();
      m_flush = mis;
   endtask

   task automatic cyc(input logic r, input logic iv, input logic [31:0] ipc, input logic ije,
                      input logic [31:0] ipred, input logic ev, input logic [31:0] epc,
                      input logic etk, input logic [31:0] etgt);
      rdy = r; if_br_valid = iv; if_pc = ipc; if_jmp_e = ije; if_pred = ipred;
      ex_br_valid = ev; ex_pc = epc; ex_taken = etk; ex_target = etgt;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic enq(input logic [31:0] pc, input logic je, input logic [31:0] pred);
      cyc(1'b1, 1'b1, pc, je, pred, 1'b0, 32'd0, 1'b0, 32'd0);
   endtask

   task automatic res(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      cyc(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, pc, tk, tgt);
   endtask

   task automatic idle(input logic r);
      cyc(r, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
   endtask

   task automatic model_reset();
      m_q.delete();
      exp_q.delete();
      m_err   = '0;
      m_flush = 1'b0;
   endtask

   // Monitor: every pulse is consumed at the negedge before the rdy=1 edge that retires it
   always @(negedge clk) begin
      if (rst) begin
         chk("err", 32'(err), 32'(m_err));
         chk("if_full", 32'(if_full), 32'(m_q.size() == DEPTH));
         chk("flush_without_jmp_r", 32'(flush && !jmp_r), 32'd0);
         if (jmp_r && rdy) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_pulse: got jmp_r=1 addr_r=%h expected no pulse", addr_r);
            end else begin
               mon_e = exp_q.pop_front();
               chk("addr_r", addr_r, mon_e.addr);
               chk("change_e", 32'(change_e), 32'(mon_e.chg));
               chk("target_addr", target_addr, mon_e.tgt);
               chk("flush", 32'(flush), 32'(mon_e.fl));
               if (mon_e.fl) chk("redirect_pc", redirect_pc, mon_e.rpc);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      ent_t h;
      logic [31:0] rpc, epc, etgt;
      logic ev, etk;

      repeat (2) @(posedge clk);
      #1;
      chk("reset_jmp_r", 32'(jmp_r), 32'd0);
      chk("reset_flush", 32'(flush), 32'd0);
      chk("reset_err", 32'(err), 32'd0);
      chk("reset_if_full", 32'(if_full), 32'd0);
      chk("reset_addr_r", addr_r, 32'd0);
      chk("reset_redirect_pc", redirect_pc, 32'd0);
      rst = 1'b1;

      // Correct not-taken prediction
      enq(32'h100, 1'b0, 32'h0);
      res(32'h100, 1'b0, 32'h104);
      idle(1'b1);

      // Target mispredict
      enq(32'h300, 1'b1, 32'h40);
      res(32'h300, 1'b1, 32'h44);
      idle(1'b1);

      // Not-taken refetch wraps past the top of the address space
      enq(32'hFFFF_FFFC, 1'b1, 32'h10);
      res(32'hFFFF_FFFC, 1'b0, 32'h10);
      idle(1'b1);

      // Full queue, overflow, then simultaneous enqueue and correct dequeue
      for (int i = 0; i < DEPTH; i++) enq(32'h400 + 32'(4 * i), 1'b0, 32'h0);
      chk("full_after_fill", 32'(if_full), 32'd1);
      enq(32'h410, 1'b0, 32'h0);
      chk("err0_after_overflow", 32'(err[0]), 32'd1);
      cyc(1'b1, 1'b1, 32'h414, 1'b0, 32'h0, 1'b1, 32'h400, 1'b0, 32'h0);
      chk("full_after_enq_deq", 32'(if_full), 32'd1);
      res(32'h404, 1'b0, 32'h0);
      res(32'h408, 1'b0, 32'h0);
      res(32'h40c, 1'b0, 32'h0);
      res(32'h414, 1'b0, 32'h0);
      idle(1'b1);

      // Direction mispredict clears younger entry; enqueue during flush is ignored
      enq(32'h200, 1'b0, 32'h0);
      enq(32'h204, 1'b1, 32'h300);
      res(32'h200, 1'b1, 32'h80);
      enq(32'h500, 1'b0, 32'h0);
      chk("if_full_after_flush", 32'(if_full), 32'd0);
      enq(32'h600, 1'b0, 32'h0);
      res(32'h600, 1'b0, 32'h604);
      idle(1'b1);

      // rdy stall holds the training pulse
      enq(32'h700, 1'b1, 32'h720);
      res(32'h700, 1'b1, 32'h720);
      for (int i = 0; i < 3; i++) begin
         idle(1'b0);
         chk("jmp_r_held_in_stall", 32'(jmp_r), 32'd1);
      end
      idle(1'b1);
      chk("jmp_r_cleared_after_stall", 32'(jmp_r), 32'd0);

      // Asynchronous reset while flushing
      enq(32'h800, 1'b0, 32'h0);
      res(32'h800, 1'b1, 32'h900);
      chk("flush_before_reset", 32'(flush), 32'd1);
      rst = 1'b0;
      model_reset();
      #1;
      chk("async_rst_flush", 32'(flush), 32'd0);
      chk("async_rst_jmp_r", 32'(jmp_r), 32'd0);
      chk("async_rst_err", 32'(err), 32'd0);
      chk("async_rst_if_full", 32'(if_full), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      enq(32'hA00, 1'b0, 32'h0);
      res(32'hA00, 1'b0, 32'hA04);
      idle(1'b1);

      // Randomized traffic against the reference model
      for (int n = 0; n < 1500; n++) begin
         rpc  = 32'($urandom) & 32'hFFFF_FFFC;
         ev   = 1'b0; epc = '0; etk = 1'b0; etgt = '0;
         if (m_q.size() > 0 && ($urandom % 3) == 0) begin
            h    = m_q[0];
            ev   = 1'b1;
            epc  = (($urandom % 16) == 0) ? (32'($urandom) & 32'hFFFF_FFFC) : h.pc;
            etk  = (($urandom % 4) == 0) ? !h.je : h.je;
            etgt = (etk && h.je && ($urandom % 4) != 0) ? h.pred : (32'($urandom) & 32'hFFFF_FFFC);
         end else if (m_q.size() == 0 && ($urandom % 32) == 0) begin
            ev  = 1'b1;
            epc = rpc;
         end
         cyc(($urandom % 8) != 0, 1'(($urandom % 2)), rpc, 1'($urandom % 2),
             32'($urandom) & 32'hFFFF_FFFC, ev, epc, etk, etgt);
      end
      repeat (4) idle(1'b1);
      chk("pending_pulses", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Branch resolution unit paired with `predictor`. It records each prediction made at fetch in an in-order queue. When the execute stage resolves a branch, it compares the actual outcome against the recorded prediction. It then drives the predictor's training port (`addr_r`, `jmp_r`, `change_e`, `target_addr`) and raises a pipeline flush with a redirect PC on mispredict.

## Interface
Parameters:
- `DEPTH`, 4: in-flight branch capacity, power of two, at least 2.
- `ADDR_W`, 32: address width (matches `InstAddrBus`).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  reset; asynchronous assert, active-low.
- `rdy`  in  1  global ready; when 0, no state changes.
- `if_br_valid`  in  1  fetch enqueues a branch this cycle.
- `if_pc`  in  ADDR_W  PC of that branch.
- `if_jmp_e`  in  1  predictor's `jmp_e` for that PC.
- `if_pred`  in  ADDR_W  predictor's `pred` for that PC.
- `if_full`  out  1  queue full; fetch must stall branch enqueue.
- `ex_br_valid`  in  1  execute resolves the oldest branch this cycle.
- `ex_pc`  in  ADDR_W  PC of resolved branch.
- `ex_taken`  in  1  actual direction.
- `ex_target`  in  ADDR_W  actual taken target.
- `addr_r`  out  ADDR_W  training PC to predictor.
- `jmp_r`  out  1  training strobe.
- `change_e`  out  1  actual taken.
- `target_addr`  out  ADDR_W  actual target.
- `flush`  out  1  squash younger instructions.
- `redirect_pc`  out  ADDR_W  refetch PC, valid while `flush`=1.
- `err`  out  2  sticky: bit0 overflow/underflow, bit1 order mismatch.

## Operation
- Queue entry: {pc, jmp_e, pred}. Pointers are `clog2(DEPTH)` bits and wrap modulo DEPTH. The count is `clog2(DEPTH)+1` bits.
- Reset values: queue empty, all outputs 0. Entry contents are don't-care.
- `if_full` = (count == DEPTH), combinational.
- Enqueue is accepted when `rdy` && `if_br_valid` && !`flush` && no mispredict this cycle. The count must also satisfy count < DEPTH, or a correctly predicted dequeue must occur in the same cycle.
- Enqueue while full without a dequeue: the entry is dropped and `err[0]` is set.
- Dequeue occurs on `rdy` && `ex_br_valid`. Dequeue while empty sets `err[0]` and produces no training or flush.
- Mispredict condition, where H is the head entry:
  - H.pc != `ex_pc` (also sets `err[1]`), or
  - `ex_taken` != H.jmp_e, or
  - `ex_taken` && H.jmp_e && `ex_target` != H.pred.
- Every valid dequeue issues one training pulse: `addr_r`=`ex_pc`, `jmp_r`=1, `change_e`=`ex_taken`, `target_addr`=`ex_target`.
- On mispredict:
  - The queue clears at the same edge; a concurrent enqueue is discarded.
  - `flush`=1 with `redirect_pc` = `ex_taken` ? `ex_target` : `ex_pc`+4, computed mod 2^ADDR_W so it wraps.
  - Enqueues are ignored while `flush`=1.
- `err` bits clear only on reset.

## Timing
- Resolution in cycle N drives training outputs and `flush`/`redirect_pc` as registered outputs in cycle N+1.
- Pulses last exactly one `rdy`=1 cycle:
  - They clear at the first edge where `rdy`=1 after assertion.
  - They hold through `rdy`=0 cycles, so the predictor (gated by `rdy`) trains once.
- Back-to-back resolutions produce back-to-back `jmp_r` pulses. `flush` may stay high on consecutive cycles only if two mispredicts resolve consecutively; the second can only occur if execute resolves before observing the flush.
- Reset mid-operation clears the queue, the pulses and `err` immediately (asynchronous). The first enqueue is accepted on the first edge after deassertion.
- Simultaneous enqueue and correctly predicted dequeue: count unchanged, both pointers advance.

## Structure
- Shared widths and constants (`InstAddrBus`, `ADDR_W` default, the `err` bit indices) go in the common defines file.
- One sub-module, `br_fifo`: a parameterized synchronous FIFO with a clear input and count output. Compare, training and flush logic live in `branch_resolver`.

## Test plan
- Correct not-taken prediction:
  - Stimulus: enqueue pc=0x100, jmp_e=0; resolve `ex_taken`=0.
  - Response: next cycle `jmp_r`=1, `change_e`=0, `addr_r`=0x100, `flush`=0.
- Direction mispredict:
  - Stimulus: enqueue pc=0x200, jmp_e=0, then pc=0x204; resolve 0x200 taken to 0x80.
  - Response: `flush`=1, `redirect_pc`=0x80, queue empty afterwards, `if_full`=0.
- Target mispredict:
  - Stimulus: enqueue pc=0x300, jmp_e=1, pred=0x40; resolve taken to 0x44.
  - Response: `flush`=1, `redirect_pc`=0x44, `target_addr`=0x44.
- Full queue (DEPTH=4):
  - Stimulus: enqueue 4 branches; assert `if_full`; enqueue a 5th.
  - Response: `err[0]`=1. Then enqueue and a correct dequeue in the same cycle keeps the count at 4.
- `rdy` stall:
  - Stimulus: resolve a branch, then drop `rdy` for 3 cycles.
  - Response: `jmp_r` stays 1 throughout and clears one cycle after `rdy` returns.
- Async reset mid-flush:
  - Stimulus: assert `rst` while `flush`=1.
  - Response: `flush`, `jmp_r`, `err` go to 0 immediately and the queue is empty.
